// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types for the memory stage: control structs, funct3 codes, FSM states.
// No logic; imported by mem_align and mem_stage.
package rv32i_types;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_f3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_fsm_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic       regf_we;
        logic [1:0] wb_sel;
    } wb_ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rs2_data;
        logic [4:0]  rd_addr;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
    } ex_stage_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rs2_data;
        logic [4:0]  rd_addr;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
        logic        trap;
    } mem_stage_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane shaping: funct3 and address offset to read/write masks, lane-replicated store data.
// Purely combinational; no backpressure.
module mem_align
    import rv32i_types::*;
(
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rs2_data,
    output logic [3:0]  rmask,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic        misaligned
);

    logic [3:0] bmask;

    // Loads and stores share the size encoding in funct3[1:0]; signedness only matters in writeback.
    always_comb begin
        bmask      = 4'b0000;
        wdata      = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: begin
                bmask = 4'b0001 << off;
                wdata = {4{rs2_data[7:0]}};
            end
            F3_LH, F3_LHU: begin
                bmask      = 4'b0011 << off;
                wdata      = {2{rs2_data[15:0]}};
                misaligned = off[0];
            end
            default: begin
                bmask      = 4'b1111;
                wdata      = rs2_data;
                misaligned = (off != 2'b00);
            end
        endcase
    end

    assign rmask = mem_read  ? bmask : 4'b0000;
    assign wmask = mem_write ? bmask : 4'b0000;

endmodule

// File: rtl/mem_stage.sv
// rv32i memory stage: latches ex_stage_reg, issues one registered dmem request per load/store.
// Request appears the cycle after the latch; mem_busy stalls the pipe until dmem_resp.
// MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of issuing.
module mem_stage
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_reg_we,
    input  logic              flush,
    input  ex_stage_t         ex_stage_reg,
    output mem_stage_t        mem_stage_reg,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_resp,
    output logic              mem_busy
);

    mem_fsm_e    state_q, state_d;
    logic [3:0]  a_rmask, a_wmask;
    logic [31:0] a_wdata;
    logic        a_misaligned;
    logic        is_ls, trap, is_mem, issue;
    logic        stray_ok;
    mem_stage_t  nxt;

    mem_align u_align (
        .mem_read   (ex_stage_reg.mem_ctrl.mem_read),
        .mem_write  (ex_stage_reg.mem_ctrl.mem_write),
        .funct3     (ex_stage_reg.mem_ctrl.funct3),
        .off        (ex_stage_reg.alu_out[1:0]),
        .rs2_data   (ex_stage_reg.rs2_data),
        .rmask      (a_rmask),
        .wmask      (a_wmask),
        .wdata      (a_wdata),
        .misaligned (a_misaligned)
    );

    assign is_ls = ex_stage_reg.mem_ctrl.mem_read | ex_stage_reg.mem_ctrl.mem_write;
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_ls & a_misaligned & ~flush;
`else
    assign trap = 1'b0;
`endif
    assign is_mem = is_ls & ~flush & ~trap;
    assign issue  = mem_reg_we & is_mem;

    // A completing response frees the port the same cycle, so a new op can issue back-to-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = REQ;
            REQ:     state_d = dmem_resp ? (issue ? REQ : IDLE) : WAIT;
            WAIT:    if (dmem_resp) state_d = issue ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_busy = (state_q == REQ || state_q == WAIT) && !dmem_resp;

    always_comb begin
        nxt                    = '0;
        nxt.alu_out            = ex_stage_reg.alu_out;
        nxt.rs2_data           = ex_stage_reg.rs2_data;
        nxt.rd_addr            = ex_stage_reg.rd_addr;
        nxt.mem_ctrl           = ex_stage_reg.mem_ctrl;
        nxt.wb_ctrl            = ex_stage_reg.wb_ctrl;
        nxt.rvfi               = ex_stage_reg.rvfi;
        nxt.rvfi.mem_addr      = {ex_stage_reg.alu_out[31:2], 2'b00};
        nxt.rvfi.mem_rmask     = is_mem ? a_rmask : 4'b0000;
        nxt.rvfi.mem_wmask     = is_mem ? a_wmask : 4'b0000;
        nxt.rvfi.mem_wdata     = (is_mem && ex_stage_reg.mem_ctrl.mem_write) ? a_wdata : '0;
        nxt.trap               = trap;
        if (trap) begin
            nxt.wb_ctrl.regf_we = 1'b0;
        end
        if (flush) begin
            nxt.rvfi.valid      = 1'b0;
            nxt.wb_ctrl.regf_we = 1'b0;
            nxt.mem_ctrl        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            mem_stage_reg <= '0;
            dmem_addr     <= '0;
            dmem_rmask    <= 4'b0000;
            dmem_wmask    <= 4'b0000;
            dmem_wdata    <= '0;
            stray_ok      <= 1'b1;
        end else begin
            state_q <= state_d;
            if (mem_reg_we) begin
                mem_stage_reg <= nxt;
            end
            // Masks pulse only on entry to REQ; address and data hold through WAIT.
            if (state_d == REQ) begin
                dmem_addr  <= {ex_stage_reg.alu_out[ADDR_W-1:2], 2'b00};
                dmem_rmask <= a_rmask;
                dmem_wmask <= a_wmask;
                dmem_wdata <= a_wdata;
            end else begin
                dmem_rmask <= 4'b0000;
                dmem_wmask <= 4'b0000;
            end
            if (state_q == REQ) begin
                stray_ok <= 1'b0;
            end
        end
    end

    // A response left over from a transaction aborted by reset is tolerated until the next request.
    a_no_adv_while_busy: assert property (@(posedge clk) disable iff (!rst)
        !(mem_reg_we && mem_busy));
    a_no_resp_in_idle: assert property (@(posedge clk) disable iff (!rst)
        !(dmem_resp && state_q == IDLE && !stray_ok));

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_reg_we = 1'b0;
    logic        flush = 1'b0;
    logic        dmem_resp = 1'b0;
    ex_stage_t   ex_stage_reg;
    mem_stage_t  mem_stage_reg;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        mem_busy;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_reg_we    (mem_reg_we),
        .flush         (flush),
        .ex_stage_reg  (ex_stage_reg),
        .mem_stage_reg (mem_stage_reg),
        .dmem_addr     (dmem_addr),
        .dmem_rmask    (dmem_rmask),
        .dmem_wmask    (dmem_wmask),
        .dmem_wdata    (dmem_wdata),
        .dmem_resp     (dmem_resp),
        .mem_busy      (mem_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ex_stage_t mk_ex(input logic rd, input logic wr, input logic [2:0] f3,
                                        input logic [31:0] alu, input logic [31:0] rs2);
        ex_stage_t e;
        e                    = '0;
        e.alu_out            = alu;
        e.rs2_data           = rs2;
        e.rd_addr            = 5'd7;
        e.mem_ctrl.mem_read  = rd;
        e.mem_ctrl.mem_write = wr;
        e.mem_ctrl.funct3    = f3;
        e.wb_ctrl.regf_we    = ~wr;
        e.rvfi.valid         = 1'b1;
        e.rvfi.pc            = 32'h0000_0080;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ex_stage_reg = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_addr",  dmem_addr, 32'h0);
        check("rst_rmask", dmem_rmask, 4'h0);
        check("rst_wmask", dmem_wmask, 4'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_busy",  mem_busy, 1'b0);
        check("rst_valid", mem_stage_reg.rvfi.valid, 1'b0);
        check("rst_regwe", mem_stage_reg.wb_ctrl.regf_we, 1'b0);
        rst = 1'b1;

        // non-memory instruction stays IDLE
        @(negedge clk); ex_stage_reg = mk_ex(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0); mem_reg_we = 1'b1;
        @(negedge clk); mem_reg_we = 1'b0; #1;
        check("alu_valid", mem_stage_reg.rvfi.valid, 1'b1);
        check("alu_rd",    mem_stage_reg.rd_addr, 5'd7);
        check("alu_rmask", dmem_rmask, 4'h0);
        check("alu_wmask", dmem_wmask, 4'h0);
        check("alu_busy",  mem_busy, 1'b0);

        // sw, response three cycles after the request
        @(negedge clk); ex_stage_reg = mk_ex(1'b0, 1'b1, 3'd2, 32'h1000_0004, 32'hDEAD_BEEF); mem_reg_we = 1'b1;
        @(negedge clk); mem_reg_we = 1'b0; #1;
        check("sw_addr",  dmem_addr, 32'h1000_0004);
        check("sw_wmask", dmem_wmask, 4'hF);
        check("sw_rmask", dmem_rmask, 4'h0);
        check("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        busy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            dmem_resp = (k == 3);
            #1;
            if (mem_busy) busy_cnt++;
            if (k == 1) check("sw_wmask_once", dmem_wmask, 4'h0);
            if (k == 2) check("sw_addr_hold", dmem_addr, 32'h1000_0004);
        end
        @(negedge clk); dmem_resp = 1'b0; #1;
        check("sw_busy_cycles", busy_cnt, 3);
        check("sw_idle_busy", mem_busy, 1'b0);

        // sb at offset 3
        @(negedge clk); ex_stage_reg = mk_ex(1'b0, 1'b1, 3'd0, 32'h2000_0003, 32'h0000_00A5); mem_reg_we = 1'b1;
        @(negedge clk); mem_reg_we = 1'b0; dmem_resp = 1'b1; #1;
        check("sb_addr",  dmem_addr, 32'h2000_0000);
        check("sb_wmask", dmem_wmask, 4'b1000);
        check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        @(negedge clk); dmem_resp = 1'b0; #1;
        check("sb_wmask_off", dmem_wmask, 4'h0);

        // lh at offset 2, zero-latency response
        @(negedge clk); ex_stage_reg = mk_ex(1'b1, 1'b0, 3'd1, 32'h3000_0006, 32'h0); mem_reg_we = 1'b1;
        @(negedge clk); mem_reg_we = 1'b0; dmem_resp = 1'b1; #1;
        check("lh_rmask", dmem_rmask, 4'b1100);
        check("lh_busy",  mem_busy, 1'b0);
        check("lh_rvfi_rmask", mem_stage_reg.rvfi.mem_rmask, 4'b1100);
        check("lh_rvfi_addr",  mem_stage_reg.rvfi.mem_addr, 32'h3000_0004);
        @(negedge clk); dmem_resp = 1'b0; #1;
        check("lh_rmask_off", dmem_rmask, 4'h0);
        check("lh_busy_after", mem_busy, 1'b0);

        // lw then sw back-to-back, response coinciding with the second latch
        @(negedge clk); ex_stage_reg = mk_ex(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0); mem_reg_we = 1'b1;
        @(negedge clk); ex_stage_reg = mk_ex(1'b0, 1'b1, 3'd2, 32'h0000_0044, 32'h1234_5678); dmem_resp = 1'b1; #1;
        check("b2b_lw_rmask", dmem_rmask, 4'hF);
        check("b2b_lw_busy",  mem_busy, 1'b0);
        @(negedge clk); mem_reg_we = 1'b0; #1;
        check("b2b_sw_wmask", dmem_wmask, 4'hF);
        check("b2b_sw_rmask", dmem_rmask, 4'h0);
        check("b2b_sw_addr",  dmem_addr, 32'h0000_0044);
        check("b2b_sw_wdata", dmem_wdata, 32'h1234_5678);
        @(negedge clk); dmem_resp = 1'b0; #1;
        check("b2b_end_wmask", dmem_wmask, 4'h0);
        check("b2b_end_busy",  mem_busy, 1'b0);

        // flushed load becomes a bubble
        @(negedge clk); ex_stage_reg = mk_ex(1'b1, 1'b0, 3'd2, 32'h0000_0050, 32'h0); mem_reg_we = 1'b1; flush = 1'b1;
        @(negedge clk); mem_reg_we = 1'b0; flush = 1'b0; #1;
        check("fl_rmask", dmem_rmask, 4'h0);
        check("fl_valid", mem_stage_reg.rvfi.valid, 1'b0);
        check("fl_regwe", mem_stage_reg.wb_ctrl.regf_we, 1'b0);
        check("fl_mread", mem_stage_reg.mem_ctrl.mem_read, 1'b0);
        check("fl_busy",  mem_busy, 1'b0);

        // reset during WAIT, then a stray response
        @(negedge clk); ex_stage_reg = mk_ex(1'b0, 1'b1, 3'd2, 32'h0000_0060, 32'hCAFE_F00D); mem_reg_we = 1'b1;
        @(negedge clk); mem_reg_we = 1'b0; #1;
        check("rw_wmask", dmem_wmask, 4'hF);
        @(negedge clk); #1;
        check("rw_wait_busy", mem_busy, 1'b1);
        rst = 1'b0; #1;
        check("rw_addr",  dmem_addr, 32'h0);
        check("rw_wdata", dmem_wdata, 32'h0);
        check("rw_busy",  mem_busy, 1'b0);
        check("rw_valid", mem_stage_reg.rvfi.valid, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); dmem_resp = 1'b1; #1;
        check("stray_busy", mem_busy, 1'b0);
        @(negedge clk); dmem_resp = 1'b0; #1;
        check("stray_rmask", dmem_rmask, 4'h0);
        check("stray_wmask", dmem_wmask, 4'h0);
        check("stray_busy2", mem_busy, 1'b0);

        // misaligned lw
        @(negedge clk); ex_stage_reg = mk_ex(1'b1, 1'b0, 3'd2, 32'h7000_0002, 32'h0); mem_reg_we = 1'b1;
        @(negedge clk); mem_reg_we = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        check("mis_rmask", dmem_rmask, 4'h0);
        check("mis_trap",  mem_stage_reg.trap, 1'b1);
        check("mis_regwe", mem_stage_reg.wb_ctrl.regf_we, 1'b0);
        check("mis_busy",  mem_busy, 1'b0);
        check("mis_rvfi_rmask", mem_stage_reg.rvfi.mem_rmask, 4'h0);
`else
        dmem_resp = 1'b1; #1;
        check("mis_rmask", dmem_rmask, 4'hF);
        check("mis_addr",  dmem_addr, 32'h7000_0000);
        check("mis_trap",  mem_stage_reg.trap, 1'b0);
        check("mis_regwe", mem_stage_reg.wb_ctrl.regf_we, 1'b1);
        @(negedge clk); dmem_resp = 1'b0;
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage of the rv32i core, between execute and writeback.
- Latches the execute-stage register and issues one aligned data-memory request per load/store, shaping byte masks and store data.
- Tracks the outstanding request and raises a busy stall until dmem_resp returns.
- Produces mem_stage_reg, which writeback consumes together with dmem_rdata, dmem_rmask, dmem_wmask and dmem_resp.

Parameters:
- ADDR_W, 32, data-memory address width.
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- mem_reg_we  in  1  advance enable from the hazard unit; latch ex_stage_reg this edge.
- flush  in  1  squash: the next latch inserts a bubble instead of ex_stage_reg.
- ex_stage_reg  in  ex_stage_t  execute output: alu_out, rs2_data, rd_addr, mem_ctrl (mem_read, mem_write, funct3), wb_ctrl, rvfi.
- mem_stage_reg  out  mem_stage_t  pipeline register to writeback.
- dmem_addr  out  32  word-aligned address ({alu_out[31:2],2'b00}).
- dmem_rmask  out  4  read byte mask; nonzero for exactly one cycle per load.
- dmem_wmask  out  4  write byte mask; nonzero for exactly one cycle per store.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_resp  in  1  memory completion, one-cycle pulse.
- mem_busy  out  1  stall request to the hazard unit.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_stage_reg all zero (rvfi.valid=0, wb_ctrl.regf_we=0).
  - dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata = 0.
  - mem_busy=0; FSM=IDLE.
- Latch: on a clk edge with mem_reg_we=1, mem_stage_reg <= ex_stage_reg.
  - If flush=1, latch a bubble instead: rvfi.valid=0, regf_we=0, mem_ctrl cleared.
  - rvfi.mem_addr, mem_rmask, mem_wmask, mem_wdata are filled with the computed request values.
- Mask and data shaping uses off = alu_out[1:0]:
  - sb: wmask = 4'b0001<<off; wdata = rs2[7:0] replicated ×4.
  - sh: wmask = 4'b0011<<off; wdata = rs2[15:0] replicated ×2.
  - sw: wmask = 4'b1111; wdata = rs2.
  - lb/lbu: rmask = 4'b0001<<off.
  - lh/lhu: rmask = 4'b0011<<off.
  - lw: rmask = 4'b1111.
  - Misaligned half/word accesses are truncated by the shift to 4 bits; no trap unless the optional feature is enabled.
- All dmem_* outputs are registered. The request appears the cycle after the instruction latches, i.e. while it sits in mem_stage_reg.
- FSM:
  - IDLE: on a latch of a load/store with no flush → REQ. Otherwise stay IDLE with masks 0.
  - REQ: masks driven for this one cycle. dmem_resp=1 → IDLE; else → WAIT.
  - WAIT: masks 0; dmem_addr and dmem_wdata held. dmem_resp=1 → IDLE.
- mem_busy = (state==REQ || state==WAIT) && !dmem_resp.
- The hazard unit keeps mem_reg_we=0 while mem_busy=1. A mem_reg_we=1 with mem_busy=1 is a protocol violation and is flagged by an assertion.
- Simultaneous dmem_resp and mem_reg_we=1 latching a new mem op (in REQ or WAIT): the new request issues next cycle and state → REQ. Back-to-back accesses therefore have zero idle cycles.
- dmem_resp while IDLE is ignored and flagged by an assertion.
- Reset asserted mid-transaction aborts the FSM to IDLE; a late dmem_resp after reset release is ignored.
- Non-memory instructions never leave IDLE.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A lh/lhu/sh with off[0]=1, or a lw/sw with off≠0, suppresses the request: masks stay 0 and the FSM stays IDLE.
  - Sets mem_stage_reg.trap=1 and mem_stage_reg.wb_ctrl.regf_we=0.
  - rvfi.mem_rmask and rvfi.mem_wmask are recorded as 0.
- Undefined: the trap field is tied 0 and masks are truncated as above.

Decomposition:
- rv32i_types holds:
  - ex_stage_t, mem_stage_t (adds trap bit), mem_ctrl_t.
  - funct3 enums lb/lh/lw/lbu/lhu, sb/sh/sw.
  - mem_fsm_e {IDLE, REQ, WAIT}.
- One sub-module, mem_align: combinational funct3/offset → rmask, wmask, wdata, misaligned flag.

Test Plan:
- sw, alu_out=0x1000_0004, rs2=0xDEADBEEF → dmem_addr=0x1000_0004, wmask=4'hF, wdata=0xDEADBEEF for one cycle. With resp 3 cycles later, mem_busy is high for exactly 3 cycles.
- sb, alu_out=0x...0003, rs2=0x0000_00A5 → wmask=4'b1000, wdata=0xA5A5A5A5.
- lh at offset 2 → rmask=4'b1100. Zero-latency resp in REQ → mem_busy never asserts; FSM REQ→IDLE.
- lw then sw back-to-back, with resp coinciding with the latch → second request issues on the next cycle, no idle cycle between mask pulses.
- Load latched with flush=1 → no mask pulse, rvfi.valid=0. Also: reset pulled low during WAIT → all outputs 0 immediately, stray resp ignored.
- MEM_MISALIGN_TRAP_EN build, lw at 0x...0002 → masks 0, trap=1, regf_we=0.
